// File: rtl/cache_ctrl_nway.sv
// N-way write-back / write-allocate cache controller FSM with per-set round-robin
// replacement and a memory handshake that tolerates stalls.
module cache_ctrl_nway #(
  parameter  int WAY_BITS = 2,
  parameter  int OFF_BITS = 2,
  parameter  int IDX_BITS = 8,
  localparam int WAYS     = 1 << WAY_BITS,
  localparam int WORDS    = 1 << OFF_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Rd,
  input  logic                wr,
  input  logic [OFF_BITS-1:0] req_offset,
  input  logic [IDX_BITS-1:0] index,
  input  logic [WAYS-1:0]     hit_vec,
  input  logic [WAYS-1:0]     valid_vec,
  input  logic [WAYS-1:0]     dirty_vec,
  input  logic                mem_stall,
  input  logic                mem_rd_valid,
  output logic                Done,
  output logic                stall_out,
  output logic                CacheHit,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [WAYS-1:0]     way_en,
  output logic                comp,
  output logic                write,
  output logic                valid_in,
  output logic                dirty_in,
  output logic                select_wb,
  output logic                select_rd,
  output logic [OFF_BITS-1:0] offset_cache,
  output logic [OFF_BITS-1:0] offset_mem,
  output logic                comp_stage,
  output logic                err
);

  localparam logic [OFF_BITS:0]   WORDS_C = (OFF_BITS+1)'(WORDS);
  localparam logic [OFF_BITS:0]   LAST_R  = (OFF_BITS+1)'(WORDS-1);
  localparam logic [OFF_BITS-1:0] LAST_K  = OFF_BITS'(WORDS-1);

  typedef enum logic [2:0] {COMP, HIT_DONE, EVICT, FILL, FINISH} state_t;
  typedef struct packed {
    logic                wr;
    logic [OFF_BITS-1:0] off;
    logic [IDX_BITS-1:0] idx;
  } req_t;

  state_t              state, nxt;
  req_t                req_q;
  logic [WAY_BITS-1:0] hit_way, hit_way_q, victim, victim_q;
  logic                vic_rr, vic_rr_q;
  logic [WAYS-1:0]     hv, vic_oh, hit_oh;
  logic                multi_hit, req_in, ev_acc, iss_acc, ret_acc;
  logic [OFF_BITS-1:0] k_q;
  logic [OFF_BITS:0]   i_q, r_q;
  logic [WAY_BITS-1:0] rr_ptr [2**IDX_BITS];

  assign hv        = hit_vec & valid_vec;
  assign multi_hit = |(hv & (hv - 1'b1));
  assign req_in    = Rd | wr;
  assign vic_oh    = WAYS'(1) << victim_q;
  assign hit_oh    = WAYS'(1) << hit_way_q;
  assign ev_acc    = (state == EVICT) && !mem_stall;
  assign iss_acc   = (state == FILL) && (i_q < WORDS_C) && !mem_stall;
  assign ret_acc   = (state == FILL) && mem_rd_valid && (r_q != WORDS_C);

  // Downward scan leaves the lowest matching way; an invalid way beats round-robin.
  always_comb begin
    hit_way = '0;
    victim  = rr_ptr[index];
    vic_rr  = 1'b1;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hv[w]) hit_way = WAY_BITS'(w);
      if (!valid_vec[w]) begin
        victim = WAY_BITS'(w);
        vic_rr = 1'b0;
      end
    end
  end

  always_comb begin
    nxt          = state;
    Done         = 1'b0;
    stall_out    = 1'b0;
    CacheHit     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    way_en       = '0;
    comp         = 1'b0;
    write        = 1'b0;
    valid_in     = 1'b0;
    dirty_in     = 1'b0;
    select_wb    = 1'b0;
    select_rd    = 1'b0;
    offset_cache = '0;
    offset_mem   = '0;
    comp_stage   = 1'b0;
    case (state)
      COMP: begin
        way_en     = '1;
        comp       = 1'b1;
        comp_stage = 1'b1;
        valid_in   = 1'b1;
        write      = wr;
        stall_out  = req_in;
        if (req_in) begin
          if (|hv)                                        nxt = HIT_DONE;
          else if (valid_vec[victim] && dirty_vec[victim]) nxt = EVICT;
          else                                            nxt = FILL;
        end
      end
      HIT_DONE: begin
        way_en   = hit_oh;
        comp     = 1'b1;
        write    = req_q.wr;
        dirty_in = req_q.wr;
        valid_in = 1'b1;
        Done     = 1'b1;
        CacheHit = 1'b1;
        nxt      = COMP;
      end
      EVICT: begin
        stall_out    = 1'b1;
        mem_wr       = 1'b1;
        select_rd    = 1'b1;
        way_en       = vic_oh;
        offset_cache = k_q;
        offset_mem   = k_q;
        if (ev_acc && k_q == LAST_K) nxt = FILL;
      end
      FILL: begin
        stall_out    = 1'b1;
        mem_rd       = (i_q < WORDS_C);
        offset_mem   = i_q[OFF_BITS-1:0];
        offset_cache = r_q[OFF_BITS-1:0];
        select_wb    = 1'b1;
        if (ret_acc) begin
          write    = 1'b1;
          valid_in = 1'b1;
          way_en   = vic_oh;
          // The word the CPU is writing takes CPU data and marks the line dirty.
          if (req_q.wr && r_q[OFF_BITS-1:0] == req_q.off) begin
            select_wb = 1'b0;
            dirty_in  = 1'b1;
          end
          if (r_q == LAST_R) nxt = FINISH;
        end
      end
      FINISH: begin
        Done   = 1'b1;
        way_en = vic_oh;
        nxt    = COMP;
      end
      default: nxt = COMP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= COMP;
      req_q     <= '0;
      hit_way_q <= '0;
      victim_q  <= '0;
      vic_rr_q  <= 1'b0;
      k_q       <= '0;
      i_q       <= '0;
      r_q       <= '0;
      err       <= 1'b0;
      for (int s = 0; s < 2**IDX_BITS; s++) rr_ptr[s] <= '0;
    end else begin
      state <= nxt;
      if (state == COMP && req_in) begin
        req_q     <= {wr, req_offset, index};
        hit_way_q <= hit_way;
        victim_q  <= victim;
        vic_rr_q  <= vic_rr;
        if (multi_hit) err <= 1'b1;
      end
      if (ev_acc)  k_q <= (k_q == LAST_K) ? '0 : k_q + 1'b1;
      if (iss_acc) i_q <= i_q + 1'b1;
      if (ret_acc) r_q <= r_q + 1'b1;
      if (state == FILL && nxt == FINISH) begin
        i_q <= '0;
        r_q <= '0;
      end
      if (state == FINISH && vic_rr_q) rr_ptr[req_q.idx] <= rr_ptr[req_q.idx] + 1'b1;
    end
  end

endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

N-way set-associative, write-back, write-allocate cache controller FSM. It sits between the CPU memory port and the tag/data arrays plus the main-memory interface. It generalises the two-way controller in three respects: a parametrised way count and line length, a per-set round-robin victim pointer, and a stall-tolerant memory handshake in place of fixed-latency banking. Tag compare, data storage and word muxing stay outside; this block issues enables, selects and offsets only.

## Interface
- WAY_BITS, 2, log2 of associativity; WAYS = 2^WAY_BITS, legal 1..3
- OFF_BITS, 2, log2 of words per line; WORDS = 2^OFF_BITS, legal 1..3
- IDX_BITS, 8, set index width; 2^IDX_BITS round-robin pointers kept internally

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rd, wr  in  1  CPU read / write request; wr wins if both are high
- req_offset  in  OFF_BITS  requested word within line
- index  in  IDX_BITS  set index
- hit_vec, valid_vec, dirty_vec  in  WAYS  per-way tag match / valid / dirty, valid in COMP
- mem_stall  in  1  memory cannot accept mem_rd/mem_wr this cycle
- mem_rd_valid  in  1  one read word returned this cycle, in issue order
- Done, stall_out, CacheHit  out  1  CPU status
- mem_rd, mem_wr  out  1  memory request (held while mem_stall)
- way_en  out  WAYS  one-hot way enable (all ones in COMP)
- comp, write, valid_in, dirty_in  out  1  tag-array controls
- select_wb  out  1  cache write data from memory (0 = CPU data)
- select_rd  out  1  memory write data from cache
- offset_cache, offset_mem  out  OFF_BITS  word offsets to cache / memory
- comp_stage  out  1  high in COMP
- err  out  1  sticky multi-hit flag

## Operation
- States: COMP, HIT_DONE, EVICT, FILL, FINISH.
- COMP:
  - way_en all ones, comp=1, write=wr, stall_out=Rd|wr.
  - Request (Rd, wr, req_offset, index) is latched on the leaving edge.
  - Hit: any bit of hit_vec&valid_vec set → HIT_DONE.
  - Miss with victim valid and dirty → EVICT. Other misses → FILL.
- Hit way: the lowest set bit of hit_vec&valid_vec. More than one bit set → err=1 until reset.
- Victim selection:
  - If any way is invalid, the lowest invalid way.
  - Otherwise rr_ptr[index].
  - Victim is registered on leaving COMP.
- HIT_DONE:
  - way_en = hit way, comp=1, write = latched wr, dirty_in = latched wr.
  - Done=1, CacheHit=1, stall_out=0 → COMP.
- EVICT:
  - Outputs: mem_wr=1, select_rd=1, way_en = victim, offset_cache = offset_mem = counter k.
  - k starts at 0 and increments only on cycles with mem_stall=0.
  - When word WORDS-1 is accepted, k clears → FILL.
- FILL uses two counters.
  - Issue counter i (offset_mem): mem_rd=1 while i<WORDS. i increments when mem_stall=0.
  - Return counter r (offset_cache): write=1, valid_in=1, way_en = victim on each mem_rd_valid; r increments.
  - On a latched write, the word r==req_offset takes select_wb=0 (CPU data) with dirty_in=1. All other words use select_wb=1.
  - On the return of word WORDS-1 → FINISH.
- FINISH:
  - Done=1, way_en = victim, stall_out=0 → COMP.
  - If the victim came from rr_ptr, rr_ptr[index] increments mod WAYS.
- stall_out=1 in EVICT and FILL.
- The latched request is completed even if Rd/wr drop mid-miss.
- mem_rd_valid while r==WORDS, or outside FILL, is ignored.

## Timing
- Reset (rst=0, asynchronous):
  - State COMP; all counters, victim register, rr_ptr array and err cleared.
  - Outputs: way_en all ones, comp=1, comp_stage=1, valid_in=1; all others 0.
- Hit latency: request in COMP cycle 0, Done/CacheHit in cycle 1, next request accepted in cycle 2.
- Clean miss, no stalls, read latency L: WORDS issue cycles; last return at cycle WORDS+L; FINISH one cycle later.
- Dirty miss adds WORDS cycles plus stall cycles.
- Offset counters wrap only by explicit clear at state exit. No modulo wrap within a state.
- mem_rd/mem_wr and offsets must hold stable while mem_stall=1.
- mem_rd_valid in the same cycle as an issue is legal; both counters advance.

## Test plan
- Hit: WAYS=4, hit_vec=0100, valid_vec=1111, Rd, index=5 → HIT_DONE cycle 1 with way_en=0100, CacheHit=1, Done=1; back in COMP cycle 2.
- Clean fill with invalid way: valid_vec=1011, Rd → victim way 2, no mem_wr, 4 mem_rd, 4 writes at offsets 0..3 with way_en=0100, rr_ptr[index] unchanged.
- Dirty eviction plus round-robin: valid_vec=1111, dirty_vec=0001, rr_ptr=0, wr, req_offset=2 → 4 mem_wr at offsets 0..3, then fill. Word 2 has select_wb=0, dirty_in=1. rr_ptr=1 after FINISH.
- mem_stall pattern 1,0,1,1,0… during EVICT/FILL → offsets and requests hold during stalls; exactly WORDS accepts per phase.
- Multi-hit: hit_vec=valid_vec=0110 → way 1 served, err=1 and stays set. Reset with rst=0 mid-FILL → immediate COMP, err=0, counters 0.
